// File: rtl/lb_reg_pkg.sv
// Shared local-bus widths and the offset layout of the fixed words that
// follow the RW register bank inside a 32-word responder window.
package lb_reg_pkg;

    localparam int LB_AW = 24;
    localparam int LB_DW = 32;
    localparam int CNT_W = 16;

    // The fixed words sit directly above the RW bank, so they move with NREG.
    function automatic logic [4:0] lb_off_id(input int nreg);
        return 5'(nreg);
    endfunction

    function automatic logic [4:0] lb_off_wrcnt(input int nreg);
        return 5'(nreg + 1);
    endfunction

    function automatic logic [4:0] lb_off_evcnt(input int nreg);
        return 5'(nreg + 2);
    endfunction

endpackage

// File: rtl/lb_read_pipe.sv
// Fixed-latency delay line for local-bus read data; the synchronous clear
// flushes any read still in flight so nothing is returned after reset.
module lb_read_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/lb_reg_responder.sv
// Local-bus target: RW control bank, ID word, write counter and a
// clear-on-read event counter, returned at a fixed read latency.
module lb_reg_responder
    import lb_reg_pkg::*;
#(
    parameter logic [LB_AW-1:0] BASE      = 24'h000000,
    parameter int               NREG      = 16,
    parameter int               READ_PIPE = 3,
    parameter logic [LB_DW-1:0] ID        = 32'h4C425231
) (
    input  logic                   lb_clk,
    input  logic                   rst_n,
    input  logic                   lb_valid,
    input  logic                   lb_rnw,
    input  logic [LB_AW-1:0]       lb_addr,
    input  logic [LB_DW-1:0]       lb_wdata,
    input  logic                   lb_renable,
    output logic [LB_DW-1:0]       lb_rdata,
    input  logic                   ext_event,
    output logic [NREG*LB_DW-1:0]  reg_out,
    output logic                   wr_stb,
    output logic [4:0]             wr_addr
);

    localparam int         IW        = $clog2(NREG);
    localparam logic [4:0] OFF_ID    = lb_off_id(NREG);
    localparam logic [4:0] OFF_WRCNT = lb_off_wrcnt(NREG);
    localparam logic [4:0] OFF_EVCNT = lb_off_evcnt(NREG);

    logic [LB_DW-1:0] r_regs [NREG];
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_evt_cnt;

    logic             w_hit;
    logic [4:0]       w_off;
    logic             w_reg_sel;
    logic             w_wr;
    logic             w_rd;
    logic             w_clr;
    logic [LB_DW-1:0] w_rd_mux;
    logic [LB_DW-1:0] w_pipe_in;

    assign w_hit     = lb_valid & (lb_addr[LB_AW-1:5] == BASE[LB_AW-1:5]);
    assign w_off     = lb_addr[4:0];
    assign w_reg_sel = (w_off < 5'(NREG));
    assign w_wr      = w_hit & ~lb_rnw & w_reg_sel;
    assign w_rd      = w_hit & lb_rnw;
    assign w_clr     = w_rd & lb_renable & (w_off == OFF_EVCNT);

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[w_off[IW-1:0]] <= lb_wdata;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            r_wr_cnt <= '0;
        end else begin
            wr_stb <= w_wr;
            if (w_wr) begin
                wr_addr  <= w_off;
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Clear wins over hold, but an event in the clearing cycle still counts.
    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            r_evt_cnt <= '0;
        end else if (w_clr) begin
            r_evt_cnt <= CNT_W'(ext_event);
        end else if (ext_event && (r_evt_cnt != '1)) begin
            r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_reg_sel)                w_rd_mux = r_regs[w_off[IW-1:0]];
        else if (w_off == OFF_ID)     w_rd_mux = ID;
        else if (w_off == OFF_WRCNT)  w_rd_mux = LB_DW'(r_wr_cnt);
        else if (w_off == OFF_EVCNT)  w_rd_mux = LB_DW'(r_evt_cnt);
    end

    // Non-read cycles feed zeros so the output can be OR-ed with other targets.
    assign w_pipe_in = w_rd ? w_rd_mux : '0;

    lb_read_pipe #(
        .DEPTH (READ_PIPE),
        .W     (LB_DW)
    ) u_read_pipe (
        .i_clk   (lb_clk),
        .i_rst_n (rst_n),
        .i_d     (w_pipe_in),
        .o_q     (lb_rdata)
    );

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign reg_out[g*LB_DW +: LB_DW] = r_regs[g];
    end

endmodule

// File: tb/tb_lb_reg_responder.sv
// Randomised scoreboard bench for lb_reg_responder against a behavioural
// register-map model; a negedge monitor checks every cycle's outputs.
module tb_lb_reg_responder;

    localparam logic [23:0] BASE = 24'h0ABC00;
    localparam int          NREG = 16;
    localparam int          RP   = 3;
    localparam logic [31:0] ID   = 32'h4C425231;

    logic                 lb_clk;
    logic                 rst_n;
    logic                 lb_valid;
    logic                 lb_rnw;
    logic [23:0]          lb_addr;
    logic [31:0]          lb_wdata;
    logic                 lb_renable;
    logic [31:0]          lb_rdata;
    logic                 ext_event;
    logic [NREG*32-1:0]   reg_out;
    logic                 wr_stb;
    logic [4:0]           wr_addr;

    lb_reg_responder #(
        .BASE(BASE), .NREG(NREG), .READ_PIPE(RP), .ID(ID)
    ) dut (
        .lb_clk(lb_clk), .rst_n(rst_n), .lb_valid(lb_valid), .lb_rnw(lb_rnw),
        .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_renable(lb_renable),
        .lb_rdata(lb_rdata), .ext_event(ext_event), .reg_out(reg_out),
        .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    typedef struct { int due; logic [31:0] data; } rd_exp_t;
    typedef struct { int due; logic [4:0]  addr; } wr_exp_t;

    rd_exp_t     rdq[$];
    wr_exp_t     wq[$];
    logic [31:0] m_reg [NREG];
    int          m_wrcnt;
    int          m_evcnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    always @(posedge lb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NREG*32-1:0] act,
                         input logic [NREG*32-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        if (off < NREG)       return m_reg[off];
        if (off == NREG)      return ID;
        if (off == NREG + 1)  return 32'(m_wrcnt);
        if (off == NREG + 2)  return 32'(m_evcnt);
        return 32'h0;
    endfunction

    // One bus cycle: drive, predict, then apply the model's state change at the edge.
    task automatic drive(input logic rst, input logic v, input logic rnw,
                         input logic [23:0] a, input logic [31:0] wd,
                         input logic ren, input logic ev);
        bit hit;
        int off;
        rd_exp_t keep_r[$];
        wr_exp_t keep_w[$];
        rst_n = rst; lb_valid = v; lb_rnw = rnw; lb_addr = a;
        lb_wdata = wd; lb_renable = ren; ext_event = ev;
        hit = v && (a[23:5] == BASE[23:5]);
        off = int'(a[4:0]);
        if (!rst) begin
            foreach (rdq[i]) if (rdq[i].due <= cyc) keep_r.push_back(rdq[i]);
            foreach (wq[i])  if (wq[i].due  <= cyc) keep_w.push_back(wq[i]);
            rdq = keep_r;
            wq  = keep_w;
        end else begin
            if (hit && rnw) rdq.push_back('{cyc + RP, model_read(off)});
            if (hit && !rnw && off < NREG) wq.push_back('{cyc + 1, a[4:0]});
        end
        @(posedge lb_clk);
        if (!rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_wrcnt = 0;
            m_evcnt = 0;
        end else begin
            if (hit && !rnw && off < NREG) begin
                m_reg[off] = wd;
                m_wrcnt    = (m_wrcnt + 1) % 65536;
            end
            if (hit && rnw && ren && off == NREG + 2) m_evcnt = ev ? 1 : 0;
            else if (ev && m_evcnt < 65535)           m_evcnt = m_evcnt + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 24'h0, 32'h0, 0, 0);
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        drive(1, 1, 0, a, d, 0, 0);
    endtask

    task automatic rd(input logic [23:0] a, input logic ren, input logic ev);
        drive(1, 1, 1, a, 32'h0, ren, ev);
    endtask

    logic [31:0]        exp_rd;
    logic               exp_stb;
    logic [4:0]         exp_wa;
    logic [NREG*32-1:0] exp_ro;

    always @(negedge lb_clk) begin
        if (mon_en) begin
            exp_rd = 32'h0;
            if (rdq.size() > 0 && rdq[0].due == cyc) exp_rd = rdq.pop_front().data;
            check("lb_rdata", {{(NREG*32-32){1'b0}}, lb_rdata}, {{(NREG*32-32){1'b0}}, exp_rd});
            exp_stb = 1'b0;
            exp_wa  = 5'h0;
            if (wq.size() > 0 && wq[0].due == cyc) begin
                exp_stb = 1'b1;
                exp_wa  = wq.pop_front().addr;
            end
            check("wr_stb", {{(NREG*32-1){1'b0}}, wr_stb}, {{(NREG*32-1){1'b0}}, exp_stb});
            if (exp_stb) check("wr_addr", {{(NREG*32-5){1'b0}}, wr_addr}, {{(NREG*32-5){1'b0}}, exp_wa});
            for (int i = 0; i < NREG; i++) exp_ro[i*32 +: 32] = m_reg[i];
            check("reg_out", reg_out, exp_ro);
        end
    end

    initial begin
        logic [23:0] ra;
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        m_wrcnt = 0;
        m_evcnt = 0;
        rst_n = 0; lb_valid = 0; lb_rnw = 0; lb_addr = '0;
        lb_wdata = '0; lb_renable = 0; ext_event = 0;
        @(posedge lb_clk);
        #1;
        mon_en = 1;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 24'h0, 32'h0, 0, 0);

        // Basic write, strobe, readback at fixed latency
        wr(BASE + 24'd3, 32'h12345678);
        idle(1);
        rd(BASE + 24'd3, 0, 0);
        idle(5);

        // Read-after-write to the same register, then back-to-back reads
        wr(BASE + 24'd5, 32'hA5A5_0F0F);
        rd(BASE + 24'd5, 0, 0);
        rd(BASE + 24'd16, 0, 0);
        rd(BASE + 24'd17, 0, 0);
        rd(BASE + 24'd18, 0, 0);
        rd(BASE + 24'd19, 0, 0);
        idle(5);

        // Event counting and clear-on-read
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 24'h0, 32'h0, 0, 1);
            idle(1);
        end
        rd(BASE + 24'd18, 1, 0);
        idle(2);
        rd(BASE + 24'd18, 1, 1);
        idle(1);
        rd(BASE + 24'd18, 0, 0);
        rd(BASE + 24'd18, 0, 0);
        idle(4);

        // Misses and writes to read-only offsets
        wr(BASE + 24'd32, 32'hDEADBEEF);
        wr(BASE + 24'd16, 32'hCAFEF00D);
        wr(BASE + 24'd19, 32'h11111111);
        rd(BASE + 24'd32, 1, 0);
        rd(BASE + 24'd17, 0, 0);
        rd(24'h000003, 0, 0);
        idle(5);

        // Reset while a read is in flight, and a write coincident with reset
        rd(BASE + 24'd3, 0, 0);
        drive(0, 1, 0, BASE + 24'd7, 32'h77777777, 0, 1);
        drive(0, 0, 0, 24'h0, 32'h0, 0, 0);
        idle(4);
        wr(BASE + 24'd3, 32'h0BADF00D);
        rd(BASE + 24'd3, 0, 0);
        rd(BASE + 24'd17, 0, 0);
        idle(5);

        // Randomised traffic around and inside the window
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = BASE + 24'($urandom_range(0, 31));
                2:       ra = BASE + 24'd32 + 24'($urandom_range(0, 31));
                default: ra = 24'($urandom);
            endcase
            drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom), ra, $urandom,
                  1'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        idle(5);

        // Saturation of the event counter; non-clearing reads
        for (int i = 0; i < 70000; i++) drive(1, 0, 0, 24'h0, 32'h0, 0, 1);
        rd(BASE + 24'd18, 0, 0);
        rd(BASE + 24'd18, 0, 0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
